// File: rtl/fp8_mul_pipe_if.sv
// Handshake/data bundle for fp8_mul_pipe: input transaction side and result side.
// The master drives operands and out_ready; the slave (the multiplier) drives results.
interface fp8_mul_pipe_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_fmt;
    logic [LANES*8-1:0]    in_a;
    logic [LANES*8-1:0]    in_b;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*16-1:0]   out_p;
    logic [TAG_W-1:0]      out_tag;
    logic [LANES-1:0]      out_ovf;
    logic [LANES-1:0]      out_unf;
    logic [LANES-1:0]      out_inv;

    modport master (
        output in_valid, in_fmt, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_ovf, out_unf, out_inv
    );

    modport slave (
        input  in_valid, in_fmt, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_ovf, out_unf, out_inv
    );
endinterface

// File: rtl/fp8_mul_pipe.sv
// Multi-lane FP8 (E4M3/E5M2) x FP8 -> FP16 multiplier, 3-stage elastic valid/ready pipeline.
// S1 decodes/classifies, S2 multiplies mantissas, S3 normalizes and drives the outputs.
module fp8_mul_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    fp8_mul_pipe_if.slave bus_io
);

    typedef struct packed {
        logic [3:0] mant;
        logic [5:0] exp;  // signed unbiased exponent
        logic       nan;
        logic       inf;
        logic       zero;
    } op_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] ma;
        logic [3:0] mb;
        logic [6:0] esum;  // signed EA + EB
        logic       inv;
        logic       inf;
        logic       zero;
    } s1_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] m;
        logic [6:0] esum;
        logic       inv;
        logic       inf;
        logic       zero;
    } s2_t;

    typedef struct packed {
        logic [15:0] p;
        logic        ovf;
        logic        unf;
        logic        inv;
    } res_t;

    function automatic op_t decode(input logic [7:0] x, input logic fmt);
        op_t        d;
        logic [4:0] e;
        logic [2:0] m;
        logic [4:0] emax;
        logic [5:0] bias;
        if (fmt) begin
            e    = x[6:2];
            m    = {x[1:0], 1'b0};
            emax = 5'd31;
            bias = 6'd15;
        end else begin
            e    = {1'b0, x[6:3]};
            m    = x[2:0];
            emax = 5'd15;
            bias = 6'd7;
        end
        d.mant = {(e != 5'd0), m};
        // Subnormals share the exponent of the smallest normal.
        d.exp  = {1'b0, (e == 5'd0) ? 5'd1 : e} - bias;
        d.nan  = (e == emax) && (m != 3'd0);
        d.inf  = (e == emax) && (m == 3'd0);
        d.zero = (e == 5'd0) && (m == 3'd0);
        return d;
    endfunction

    function automatic s1_t stage1(input logic [7:0] a, input logic [7:0] b, input logic fmt);
        op_t da;
        op_t db;
        s1_t r;
        da     = decode(a, fmt);
        db     = decode(b, fmt);
        r.sign = a[7] ^ b[7];
        r.ma   = da.mant;
        r.mb   = db.mant;
        r.esum = {da.exp[5], da.exp} + {db.exp[5], db.exp};
        r.inv  = da.nan | db.nan | (da.inf & db.zero) | (db.inf & da.zero);
        r.inf  = da.inf | db.inf;
        r.zero = da.zero | db.zero;
        return r;
    endfunction

    function automatic s2_t stage2(input s1_t s);
        s2_t r;
        r.sign = s.sign;
        r.m    = s.ma * s.mb;
        r.esum = s.esum;
        r.inv  = s.inv;
        r.inf  = s.inf;
        r.zero = s.zero;
        return r;
    endfunction

    function automatic res_t stage3(input s2_t s);
        res_t              r;
        logic [2:0]        l;
        logic signed [7:0] be;
        logic [17:0]       sh;
        r = '0;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            if (s.m[i]) l = 3'(i);
        end
        // Biased FP16 exponent: EA + EB + L - 6 + 15.
        be = $signed({s.esum[6], s.esum}) + $signed({5'b0, l}) + 8'sd9;
        sh = {s.m, 10'b0} >> l;
        if (s.inv) begin
            r.p   = {s.sign, 5'h1F, 10'h200};
            r.inv = 1'b1;
        end else if (s.inf) begin
            r.p = {s.sign, 5'h1F, 10'h000};
        end else if (s.zero || (s.m == 8'd0)) begin
            r.p = {s.sign, 15'h0000};
        end else if (be >= 8'sd31) begin
            r.p   = {s.sign, 5'h1F, 10'h000};
            r.ovf = 1'b1;
        end else if (be <= 8'sd0) begin
            r.p   = {s.sign, 15'h0000};
            r.unf = 1'b1;
        end else begin
            r.p = {s.sign, be[4:0], sh[9:0]};
        end
        return r;
    endfunction

    logic                   v1_q, v2_q, v3_q;
    logic                   rdy1, rdy2, rdy3;
    logic [TAG_W-1:0]       t1_q, t2_q, t3_q;
    s1_t  [LANES-1:0]       s1_q, s1_d;
    s2_t  [LANES-1:0]       s2_q, s2_d;
    res_t [LANES-1:0]       s3_q, s3_d;

    assign rdy3 = ~v3_q | bus_io.out_ready;
    assign rdy2 = ~v2_q | rdy3;
    assign rdy1 = ~v1_q | rdy2;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_d[i] = stage1(bus_io.in_a[8*i +: 8], bus_io.in_b[8*i +: 8], bus_io.in_fmt);
            s2_d[i] = stage2(s1_q[i]);
            s3_d[i] = stage3(s2_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            t1_q <= '0;
            t2_q <= '0;
            t3_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (rdy1) v1_q <= bus_io.in_valid;
            if (rdy1 && bus_io.in_valid) begin
                s1_q <= s1_d;
                t1_q <= bus_io.in_tag;
            end
            if (rdy2) v2_q <= v1_q;
            if (rdy2 && v1_q) begin
                s2_q <= s2_d;
                t2_q <= t1_q;
            end
            if (rdy3) v3_q <= v2_q;
            if (rdy3 && v2_q) begin
                s3_q <= s3_d;
                t3_q <= t2_q;
            end
        end
    end

    assign bus_io.in_ready  = rdy1;
    assign bus_io.out_valid = v3_q;
    assign bus_io.out_tag   = t3_q;

    always_comb begin
        bus_io.out_p   = '0;
        bus_io.out_ovf = '0;
        bus_io.out_unf = '0;
        bus_io.out_inv = '0;
        for (int i = 0; i < LANES; i++) begin
            bus_io.out_p[16*i +: 16] = s3_q[i].p;
            bus_io.out_ovf[i]        = s3_q[i].ovf;
            bus_io.out_unf[i]        = s3_q[i].unf;
            bus_io.out_inv[i]        = s3_q[i].inv;
        end
    end

endmodule

// File: tb/tb_fp8_mul_pipe.sv
// Self-checking bench for fp8_mul_pipe: vector table driven through a scoreboard queue,
// plus latency, backpressure and mid-stream reset sequences.
module tb_fp8_mul_pipe;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 4;
    localparam int          NVEC  = 7;

    typedef struct {
        logic        fmt;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic [3:0]  ovf;
        logic [3:0]  unf;
        logic [3:0]  inv;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] p;
        logic [11:0] flags;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic rand_rdy = 1'b0;
    vec_t vecs[NVEC];
    exp_t q[$];

    fp8_mul_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    fp8_mul_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every result transferred out against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output_tag", {60'b0, bus.out_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("out_tag", {60'b0, bus.out_tag}, {60'b0, e.tag});
                chk("out_p", bus.out_p, e.p);
                chk("out_flags", {52'b0, bus.out_ovf, bus.out_unf, bus.out_inv},
                    {52'b0, e.flags});
            end
        end
    end

    task automatic send(input vec_t v, input logic [3:0] tag);
        exp_t e;
        logic accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_fmt   = v.fmt;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_tag   = tag;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.tag   = tag;
                e.p     = v.p;
                e.flags = {v.ovf, v.unf, v.inv};
                q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            if (accepted) break;
        end
        if (!accepted) chk("send_accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int w = 0; w < 60; w++) begin
            if (q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        chk("drain_out_valid_low", {63'b0, bus.out_valid}, 64'd0);
    endtask

    task automatic latency_test(input vec_t v, input logic [3:0] tag);
        int cyc;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        send(v, tag);
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency_cycles", 64'(cyc), 64'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap_p;
        logic [3:0]  snap_t;
        logic        have_snap;
        int          idx;

        // fmt, a, b, p, ovf, unf, inv  (lane 0 in the low byte / halfword)
        vecs[0] = '{1'b0, 32'h38383838, 32'h38383838, 64'h3C00_3C00_3C00_3C00, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{1'b0, 32'h80B80101, 32'h38380170, 64'h8000_BC00_0000_3400, 4'h0, 4'b0010, 4'h0};
        vecs[2] = '{1'b1, 32'h7CFB7B3C, 32'h3C7B7B40, 64'h7C00_FC00_7C00_4000, 4'b0110, 4'h0, 4'h0};
        vecs[3] = '{1'b0, 32'h00787978, 32'h79383880, 64'h7E00_7C00_7E00_FE00, 4'h0, 4'h0, 4'b1011};
        vecs[4] = '{1'b1, 32'h457E0101, 32'hC6007B01, 64'hCF80_7E00_3B00_0000, 4'h0, 4'b0001, 4'b0100};
        vecs[5] = '{1'b0, 32'h40070877, 32'hC8070877, 64'hC800_0A20_0C00_7B08, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{1'b1, 32'h1C1C585C, 32'h20245C5C, 64'h0000_0400_7800_7C00, 4'b0001, 4'b1000, 4'h0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("reset_out_p", bus.out_p, 64'd0);
        chk("reset_out_tag", {60'b0, bus.out_tag}, 64'd0);
        chk("reset_flags", {52'b0, bus.out_ovf, bus.out_unf, bus.out_inv}, 64'd0);
        chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        latency_test(vecs[0], 4'hA);
        drain();

        // Back-to-back table stream with out_ready high.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) send(vecs[i], 4'(i));
        drain();

        // Same table under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < NVEC; i++) send(vecs[i], 4'(i + 8));
        rand_rdy = 1'b0;
        drain();

        // Stalled output: only three transactions fit, outputs hold.
        bus.out_ready = 1'b0;
        have_snap     = 1'b0;
        snap_p        = '0;
        snap_t        = '0;
        idx           = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_fmt   = vecs[idx % NVEC].fmt;
            bus.in_a     = vecs[idx % NVEC].a;
            bus.in_b     = vecs[idx % NVEC].b;
            bus.in_tag   = 4'(idx);
            @(negedge clk);
            if (bus.out_valid) begin
                if (!have_snap) begin
                    snap_p    = bus.out_p;
                    snap_t    = bus.out_tag;
                    have_snap = 1'b1;
                    chk("stall_head_tag", {60'b0, bus.out_tag}, 64'd0);
                end else begin
                    chk("stall_hold_p", bus.out_p, snap_p);
                    chk("stall_hold_tag", {60'b0, bus.out_tag}, {60'b0, snap_t});
                end
            end
            if (bus.in_ready) begin
                q.push_back('{4'(idx), vecs[idx % NVEC].p,
                              {vecs[idx % NVEC].ovf, vecs[idx % NVEC].unf, vecs[idx % NVEC].inv}});
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("stall_accept_count", 64'(idx), 64'd3);
        chk("stall_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
        chk("stall_out_seen", {63'b0, have_snap}, 64'd1);
        bus.out_ready = 1'b1;
        for (int k = idx; k < 6; k++) send(vecs[k % NVEC], 4'(k));
        drain();

        // Reset with the pipeline full.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(vecs[k + 1], 4'(k + 3));
        chk("pre_reset_out_valid", {63'b0, bus.out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("async_reset_out_p", bus.out_p, 64'd0);
        chk("async_reset_out_tag", {60'b0, bus.out_tag}, 64'd0);
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        chk("post_reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("post_reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        latency_test(vecs[5], 4'h7);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp8_mul_pipe.md
Name: fp8_mul_pipe

Overview:
Multi-lane, pipelined FP8×FP8→FP16 multiplier; next generation of the team's combinational E4M3 product unit.
- Adds: per-transaction format select (E4M3 or E5M2), correct subnormal-input handling, FP16 overflow detection, per-lane exception flags, and a valid/ready elastic 3-stage pipeline with tag passthrough.
- Feeds the tensor-core FP16 accumulation tree.

Parameters:
LANES, 4, number of independent multiplier lanes per transaction
TAG_W, 4, width of opaque tag carried alongside each transaction

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  pipeline can accept input this cycle
in_fmt  input  1  0 = E4M3 (bias 7), 1 = E5M2 (bias 15); applies to all lanes of the transaction
in_a  input  LANES*8  operand A, lane i at [8i+7:8i]
in_b  input  LANES*8  operand B, same packing
in_tag  input  TAG_W  transaction tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_p  output  LANES*16  FP16 products, lane i at [16i+15:16i]
out_tag  output  TAG_W  tag of the presented result
out_ovf  output  LANES  lane result overflowed to ±inf
out_unf  output  LANES  lane nonzero result flushed to ±0
out_inv  output  LANES  lane invalid: NaN input, or inf×0

Behaviour:
- Reset (asynchronous, active-low): all stage valids = 0, out_valid = 0, out_p = 0, out_tag = 0, all flags = 0. Any in-flight transactions are dropped; no partial output.
- Pipeline stages:
  - S1: decode/classify.
  - S2: mantissa multiply and exponent sum.
  - S3: normalize/pack; S3 drives the out_* ports directly.
- Handshake:
  - Stage k loads when ready_k = ~valid_k | ready_{k+1}; ready_4 = out_ready.
  - in_ready = ready_1, which is combinational from out_ready through the stage valids.
  - Transfer occurs when valid & ready are both high.
  - Latency is 3 cycles from input accept to out_valid when out_ready is held high; throughput is 1 transaction/cycle.
  - out_* hold stable while out_valid & ~out_ready. Order is strictly preserved.
  - Capacity is 3 transactions.
- Decode per lane:
  - E4M3: e = [6:3], m = [2:0].
  - E5M2: e = [6:2], m = {[1:0], 0}.
  - Hidden bit h = (e != 0).
  - Effective unbiased exponent E = max(e, 1) − bias, so subnormal inputs use exponent 1 − bias.
  - Exponent field all-ones (15 for E4M3, 31 for E5M2): m == 0 is inf; otherwise NaN.
  - Zero: e == 0 and m == 0.
- Arithmetic:
  - M = {hA, mA} × {hB, mB}, 8-bit; product value = M × 2^−6.
  - If M == 0 the result is ±0 with no flag.
  - Otherwise let L = index of the leading one of M (0..7).
  - Unbiased result exponent X = EA + EB + L − 6; biased FP16 exponent = X + 15.
  - FP16 fraction = bits M[L−1:0], left-aligned in 10 bits. The result is always exact, so no rounding.
- Range:
  - Biased exponent ≥ 31: result ±inf (0x7C00 | sign), ovf = 1.
  - Biased exponent ≤ 0 with M ≠ 0: result ±0, unf = 1. No FP16 subnormal outputs.
- Specials, in priority order:
  1. NaN input, or inf×0: result {sign, 0x1F, 0x200}, inv = 1.
  2. Inf × nonzero: result ±inf, no flag.
  3. Zero operand: result ±0.
- Sign is always signA ^ signB, including for zeros and NaN.
- Lanes are fully independent; flags are valid only when out_valid = 1.

Test Plan:
1. E4M3, all lanes A=0x38, B=0x38, out_ready=1 → out_p lanes = 0x3C00, flags 0, out_valid exactly 3 cycles after accept, tag echoed.
2. E4M3 subnormal input: A=0x01 (2^−9), B=0x70 (2^7) → 0x3400; second lane A=0x01, B=0x01 → 0x0000 with unf=1.
3. E5M2 mixed lanes:
   - 0x3C×0x40 → 0x4000.
   - 0x7B×0x7B → 0x7C00 with ovf=1.
   - 0xFB×0x7B → 0xFC00 with ovf=1.
4. E4M3 specials:
   - 0x78×0x80 → 0xFE00, inv=1.
   - 0x79×0x38 → 0x7E00, inv=1.
   - 0x78×0x38 → 0x7C00, no flag.
5. Backpressure: send 6 back-to-back transactions (tags 0..5) with out_ready=0 for 5 cycles → in_ready drops after 3 accepts; out_* hold stable while stalled; all 6 results emerge in tag order with none lost or duplicated.
6. Reset mid-stream: assert rst_n=0 asynchronously with 3 transactions in flight → out_valid and out_p go to 0 immediately; after release, in_ready=1 and a new transaction completes with 3-cycle latency.
